// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and command sequencer for the single-port mem_controller
module mem_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [2:0]               p0_func3,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]    p0_wdata,
  output logic                     p0_done,
  output logic                     p0_err,
  output logic [DATA_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [2:0]               p1_func3,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]    p1_wdata,
  output logic                     p1_done,
  output logic                     p1_err,
  output logic [DATA_WIDTH-1:0]    p1_rdata,
  output logic                     mem_read_en,
  output logic                     mem_write_en,
  output logic [2:0]               mem_func3,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     grant_id
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, RESP} state_t;

  state_t                   state, state_next;
  logic                     last_grant;
  logic                     we_q;
  logic [TW-1:0]            tcnt, tcnt_inc;
  logic                     pick, timeout_hit, complete_ok;
  logic                     sel_we;
  logic [2:0]               sel_func3;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  always_comb begin
    state_next  = state;
    pick        = p1_req;
    timeout_hit = 1'b0;
    complete_ok = (state == WAIT_HIGH) && mem_ready;
    tcnt_inc    = (tcnt == {TW{1'b1}}) ? tcnt : tcnt + 1'b1;
    // On a tie, round-robin favours the port that did not win last time.
    if (p0_req && p1_req) pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    sel_we    = pick ? p1_we    : p0_we;
    sel_func3 = pick ? p1_func3 : p0_func3;
    sel_addr  = pick ? p1_addr  : p0_addr;
    sel_wdata = pick ? p1_wdata : p0_wdata;
    if (TIMEOUT_CYCLES != 0 && (state == WAIT_LOW || state == WAIT_HIGH))
      timeout_hit = (tcnt_inc == TW'(TIMEOUT_CYCLES));
    case (state)
      IDLE:      if (mem_ready && (p0_req || p1_req)) state_next = ISSUE;
      ISSUE:     state_next = WAIT_LOW;
      WAIT_LOW:  if (!mem_ready) state_next = WAIT_HIGH;
                 else if (timeout_hit) state_next = RESP;
      WAIT_HIGH: if (mem_ready || timeout_hit) state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      we_q         <= 1'b0;
      tcnt         <= '0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_func3    <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      p0_err       <= 1'b0;
      p1_err       <= 1'b0;
      busy         <= (state_next != IDLE);
      case (state)
        IDLE: if (state_next == ISSUE) begin
          grant_id     <= pick;
          we_q         <= sel_we;
          mem_func3    <= sel_func3;
          mem_address  <= sel_addr;
          mem_data_in  <= sel_wdata;
          mem_read_en  <= ~sel_we;
          mem_write_en <= sel_we;
        end
        ISSUE: tcnt <= '0;
        WAIT_LOW, WAIT_HIGH: begin
          tcnt <= tcnt_inc;
          if (state_next == RESP) begin
            p0_done <= ~grant_id;
            p1_done <= grant_id;
            p0_err  <= ~grant_id & ~complete_ok;
            p1_err  <= grant_id & ~complete_ok;
            if (complete_ok && !we_q) begin
              if (grant_id) p1_rdata <= mem_data_out;
              else          p0_rdata <= mem_data_out;
            end
          end
        end
        RESP: last_grant <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench: round-robin and fixed-priority arbiters, each with a controller model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        p0_req = 1'b0, p1_req = 1'b0, p0_we = 1'b0, p1_we = 1'b0;
  logic [2:0]  p0_func3 = '0, p1_func3 = '0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (f3)
      3'd0: r[{a, 3'b000} +: 8] = d[7:0];
      3'd1: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      3'd2: r = d;
      default: ;
    endcase
    return r;
  endfunction

  // Instance 0 is round-robin, instance 1 fixed priority; both see the same port stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        p0_done, p1_done, p0_err, p1_err, busy, grant_id;
    logic [31:0] p0_rdata, p1_rdata, mem_address, mem_data_in, mem_data_out;
    logic        mem_read_en, mem_write_en, mem_ready;
    logic [2:0]  mem_func3;
    logic [31:0] mem [64];
    int          cnt;

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(g), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_func3(p0_func3), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_func3(p1_func3), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_func3(mem_func3),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .mem_ready(mem_ready), .busy(busy), .grant_id(grant_id)
    );

    // ready drops the cycle after a strobe: 1 cycle for SW, 4 otherwise, 70 when stalled
    always @(posedge clk) begin
      if (rst) begin
        mem_ready    <= 1'b1;
        cnt          <= 0;
        mem_data_out <= '0;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mem_ready <= 1'b1;
      end else if (mem_read_en || mem_write_en) begin
        mem_ready <= 1'b0;
        cnt <= stall ? 70 : (mem_write_en && mem_func3 == 3'd2) ? 1 : 4;
        if (mem_read_en)
          mem_data_out <= load_fmt(mem[mem_address[7:2]], mem_func3, mem_address[1:0]);
        else
          mem[mem_address[7:2]] <= store_merge(mem[mem_address[7:2]], mem_data_in, mem_func3, mem_address[1:0]);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 32'({g_inst[0].p0_done, g_inst[0].p1_done, g_inst[0].p0_err, g_inst[0].p1_err,
                              g_inst[0].busy, g_inst[0].grant_id, g_inst[0].mem_read_en,
                              g_inst[0].mem_write_en, g_inst[0].mem_func3}), 32'h0);
    check({tag, "_addr"}, g_inst[0].mem_address, 32'h0);
    check({tag, "_din"}, g_inst[0].mem_data_in, 32'h0);
    check({tag, "_rdata"}, g_inst[0].p0_rdata | g_inst[0].p1_rdata, 32'h0);
  endtask

  task automatic xact(input string tag, input logic port, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int  n, wr, rd, stray;
    logic done, err;
    n = 0; wr = 0; rd = 0; stray = 0; done = 1'b0; err = 1'b0;
    if (port) begin
      p1_we = we; p1_func3 = f3; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_func3 = f3; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      wr += int'(g_inst[0].mem_write_en);
      rd += int'(g_inst[0].mem_read_en);
      stray += int'(port ? g_inst[0].p0_done : g_inst[0].p1_done);
      done = port ? g_inst[0].p1_done : g_inst[0].p0_done;
      err  = port ? g_inst[0].p1_err  : g_inst[0].p0_err;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_rdata"}, port ? g_inst[0].p1_rdata : g_inst[0].p0_rdata, exp_rdata);
    check({tag, "_strobes"}, {wr[15:0], rd[15:0]}, {15'h0, we, 15'h0, ~we});
    check({tag, "_stray_done"}, stray, 0);
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int order[4];
    int idx, fp_p0, fp_p1, n;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    xact("sw_p0",  1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0);
    xact("lw_p0",  1'b0, 1'b0, 3'd2, 32'h10, 32'h0,        7, 1'b0, 32'hDEADBEEF);
    xact("sw_p1",  1'b1, 1'b1, 3'd2, 32'h20, 32'h000000F0, 4, 1'b0, 32'h0);
    xact("lb_p1",  1'b1, 1'b0, 3'd0, 32'h20, 32'h0,        7, 1'b0, 32'hFFFFFFF0);
    xact("lbu_p1", 1'b1, 1'b0, 3'd4, 32'h20, 32'h0,        7, 1'b0, 32'h000000F0);
    xact("sb_p0",  1'b0, 1'b1, 3'd0, 32'h13, 32'h000000AB, 7, 1'b0, 32'hDEADBEEF);
    xact("lh_p0",  1'b0, 1'b0, 3'd1, 32'h12, 32'h0,        7, 1'b0, 32'hFFFFABAD);

    stall = 1'b1;
    xact("timeout", 1'b0, 1'b0, 3'd2, 32'h20, 32'h0, 66, 1'b1, 32'hFFFFABAD);
    stall = 1'b0;
    check("timeout_idle", 32'(g_inst[0].busy), 32'h0);
    n = 0;
    while (!g_inst[0].mem_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_ready_back", 32'(g_inst[0].mem_ready), 32'h1);

    p0_we = 1'b0; p0_func3 = 3'd2; p0_addr = 32'h10; p0_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_busy", 32'(g_inst[0].busy), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("mid_reset");
    rst = 1'b0; p0_req = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clk); #1; n += int'(g_inst[0].p0_done | g_inst[0].p1_done); end
    check("mid_no_done", n, 0);
    xact("lw_after_rst", 1'b0, 1'b0, 3'd2, 32'h10, 32'h0, 7, 1'b0, 32'hABADBEEF);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p0_we = 1'b0; p0_func3 = 3'd2; p0_addr = 32'h10;
    p1_we = 1'b0; p1_func3 = 3'd4; p1_addr = 32'h20;
    p0_req = 1'b1; p1_req = 1'b1;
    idx = 0; fp_p0 = 0; fp_p1 = 0; n = 0;
    while (idx < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
      fp_p0 += int'(g_inst[1].p0_done);
      fp_p1 += int'(g_inst[1].p1_done);
      if (g_inst[0].p0_done || g_inst[0].p1_done) begin
        order[idx] = int'(g_inst[0].p1_done);
        check("rr_done_owner", 32'({g_inst[0].p0_done, g_inst[0].p1_done}),
              32'(g_inst[0].grant_id ? 2'b01 : 2'b10));
        check("rr_rdata", g_inst[0].p1_done ? g_inst[0].p1_rdata : g_inst[0].p0_rdata,
              g_inst[0].p1_done ? 32'h000000F0 : 32'hABADBEEF);
        idx++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check("rr_count", idx, 4);
    for (int i = 0; i < idx; i++) check("rr_order", order[i], i % 2);
    check("fp_p0_wins", fp_p0, 4);
    check("fp_p1_starves", fp_p1, 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
